// File: rtl/alu_operand_stage.sv
// Decode/operand-fetch stage feeding the ALU: 16x32 register file, writeback-pending
// scoreboard for RAW/WAW stalls, and a single registered output slot with valid/ready.
module alu_operand_stage #(
  parameter int NREGS = 16,
  parameter int IMM_W = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [7:0]  ALU_Sel,
  output logic [3:0]  out_rd,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_data
);

  logic [7:0]       op;
  logic [3:0]       rd;
  logic [3:0]       rs1;
  logic [3:0]       rs2;
  logic             use_imm;
  logic [IMM_W-1:0] imm;

  logic [31:0]      regs_q [NREGS];
  logic [31:0]      regs_d [NREGS];
  logic [NREGS-1:0] sb_q;
  logic [NREGS-1:0] sb_d;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [7:0]       sel_q, sel_d;
  logic [3:0]       rd_q, rd_d;

  logic             is_nop;
  logic             pend_rs1, pend_rs2, pend_rd;
  logic             hazard;
  logic             accept;
  logic [31:0]      rs1_val, rs2_val;

  assign op      = in_instr[31:24];
  assign rd      = in_instr[23:20];
  assign rs1     = in_instr[19:16];
  assign rs2     = in_instr[15:12];
  assign use_imm = in_instr[11];
  assign imm     = in_instr[IMM_W-1:0];
  assign is_nop  = (op == 8'd0);

  // A writeback landing this cycle already counts as resolved, so the stall lifts immediately.
  always_comb begin
    pend_rs1 = sb_q[rs1] && !(wb_en && wb_addr == rs1) && (rs1 != 4'd0);
    pend_rs2 = sb_q[rs2] && !(wb_en && wb_addr == rs2) && (rs2 != 4'd0);
    pend_rd  = sb_q[rd]  && !(wb_en && wb_addr == rd)  && (rd  != 4'd0);
    hazard   = !is_nop && (pend_rs1 || (!use_imm && pend_rs2) || ((rd != 4'd0) && pend_rd));
  end

  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    rs1_val = regs_q[rs1];
    rs2_val = regs_q[rs2];
    if (rs1 == 4'd0) begin
      rs1_val = 32'd0;
    end else if (wb_en && wb_addr == rs1) begin
      rs1_val = wb_data;
    end
    if (rs2 == 4'd0) begin
      rs2_val = 32'd0;
    end else if (wb_en && wb_addr == rs2) begin
      rs2_val = wb_data;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_en && wb_addr != 4'd0) begin
      regs_d[wb_addr] = wb_data;
    end
  end

  // Clear is applied before set so a same-cycle set on the same bit wins.
  always_comb begin
    sb_d = sb_q;
    if (wb_en) begin
      sb_d[wb_addr] = 1'b0;
    end
    if (accept && !is_nop && rd != 4'd0) begin
      sb_d[rd] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    rd_d        = rd_q;
    if (accept) begin
      out_valid_d = 1'b1;
      a_d         = rs1_val;
      b_d         = use_imm ? {{(32-IMM_W){imm[IMM_W-1]}}, imm} : rs2_val;
      sel_d       = op;
      rd_d        = rd;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= 32'd0;
      end
      sb_q        <= '0;
      out_valid_q <= 1'b0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      sel_q       <= 8'd0;
      rd_q        <= 4'd0;
    end else begin
      regs_q      <= regs_d;
      sb_q        <= sb_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      rd_q        <= rd_d;
    end
  end

  assign out_valid = out_valid_q;
  assign A         = a_q;
  assign B         = b_q;
  assign ALU_Sel   = sel_q;
  assign out_rd    = rd_q;

endmodule
